// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: instruction decode slot with a ready/valid handshake on both
// sides. Each accepted word is classified by opcode into an immediate format,
// held in the main output register and expanded to a 64-bit sign-extended
// immediate by the imm_ext helper.
// Build option: define IMM_DECODE_CTRL_SKID_EN to add a skid register and a FULL
// state. With the skid register, IN_READY is registered and the block keeps full
// throughput behind a stalled consumer. Without it, IN_READY is combinational
// (!OUT_VALID || OUT_READY).
`timescale 1ns/1ps

// imm_ext: expands the immediate field of an instruction word for a given format.
module imm_ext (
    input  logic [31:7] i_ins,
    input  logic [2:0]  i_type,
    output logic [63:0] o_imm
);

    // Select and sign-extend the immediate bits for the format; rtype/ntype give 0.
    always_comb begin
        o_imm = 64'd0;
        case (i_type)
            3'd1:    o_imm = {{52{i_ins[31]}}, i_ins[31:20]};
            3'd2:    o_imm = {{52{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
            3'd3:    o_imm = {{51{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25],
                              i_ins[11:8], 1'b0};
            3'd4:    o_imm = {{32{i_ins[31]}}, i_ins[31:12], 12'd0};
            3'd5:    o_imm = {{43{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20],
                              i_ins[30:21], 1'b0};
            default: o_imm = 64'd0;
        endcase
    end

endmodule

module imm_decode_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_INS,
    input  logic [63:0] IN_PC,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INS,
    output logic [63:0] OUT_PC,
    output logic [2:0]  OUT_TYPE,
    output logic [63:0] OUT_IMM,
    output logic        OUT_ILLEGAL
);

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;
    localparam logic [2:0] TYPE_N = 3'd6;

`ifdef IMM_DECODE_CTRL_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1} state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;

    logic        w_push;
    logic        w_pop;
    logic        w_load_main_in;
    logic [2:0]  w_in_type;
    logic        w_in_illegal;

    logic [31:0] r_ins;
    logic [63:0] r_pc;
    logic [2:0]  r_type;
    logic        r_illegal;

`ifdef IMM_DECODE_CTRL_SKID_EN
    logic        r_in_ready;
    logic        w_load_skid;
    logic        w_load_main_skid;
    logic [31:0] r_skid_ins;
    logic [63:0] r_skid_pc;
    logic [2:0]  r_skid_type;
    logic        r_skid_illegal;

    assign IN_READY = r_in_ready;
`else
    // Single slot: room is available when empty or when the held beat leaves now.
    assign IN_READY = !OUT_VALID || OUT_READY;
`endif

    assign OUT_VALID   = (r_state != ST_EMPTY);
    assign w_push      = IN_VALID && IN_READY;
    assign w_pop       = OUT_VALID && OUT_READY;

    assign OUT_INS     = r_ins;
    assign OUT_PC      = r_pc;
    assign OUT_TYPE    = r_type;
    assign OUT_ILLEGAL = r_illegal;

    imm_ext u_imm_ext (
        .i_ins  (r_ins[31:7]),
        .i_type (r_type),
        .o_imm  (OUT_IMM)
    );

    // Classify the incoming opcode; unknown opcodes are ntype and flagged illegal.
    always_comb begin
        w_in_type    = TYPE_N;
        w_in_illegal = 1'b0;
        case (IN_INS[6:0])
            7'b0110011, 7'b0111011:
                w_in_type = TYPE_R;
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:
                w_in_type = TYPE_I;
            7'b0100011:
                w_in_type = TYPE_S;
            7'b1100011:
                w_in_type = TYPE_B;
            7'b0110111, 7'b0010111:
                w_in_type = TYPE_U;
            7'b1101111:
                w_in_type = TYPE_J;
            default: begin
                w_in_type    = TYPE_N;
                w_in_illegal = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a flush empties the block regardless of handshakes.
    always_comb begin
        w_next_state = r_state;
        if (FLUSH) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) w_next_state = ST_ONE;
                    else        w_next_state = ST_EMPTY;
                end
`ifdef IMM_DECODE_CTRL_SKID_EN
                ST_ONE: begin
                    if (w_push && !w_pop)      w_next_state = ST_FULL;
                    else if (!w_push && w_pop) w_next_state = ST_EMPTY;
                    else                       w_next_state = ST_ONE;
                end
                ST_FULL: begin
                    if (w_pop) w_next_state = ST_ONE;
                    else       w_next_state = ST_FULL;
                end
`else
                ST_ONE: begin
                    if (w_pop && !w_push) w_next_state = ST_EMPTY;
                    else                  w_next_state = ST_ONE;
                end
`endif
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Output logic: register load strobes; a flush suppresses every load.
    always_comb begin
        w_load_main_in = 1'b0;
`ifdef IMM_DECODE_CTRL_SKID_EN
        w_load_skid      = 1'b0;
        w_load_main_skid = 1'b0;
`endif
        if (FLUSH) begin
            w_load_main_in = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: w_load_main_in = w_push;
`ifdef IMM_DECODE_CTRL_SKID_EN
                ST_ONE: begin
                    w_load_main_in = w_push && w_pop;
                    w_load_skid    = w_push && !w_pop;
                end
                ST_FULL: w_load_main_skid = w_pop;
`else
                ST_ONE: w_load_main_in = w_push;
`endif
                default: w_load_main_in = 1'b0;
            endcase
        end
    end

    // Main register: takes a new beat directly, or the skid beat when draining.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ins     <= 32'd0;
            r_pc      <= 64'd0;
            r_type    <= TYPE_R;
            r_illegal <= 1'b0;
        end else if (w_load_main_in) begin
            r_ins     <= IN_INS;
            r_pc      <= IN_PC;
            r_type    <= w_in_type;
            r_illegal <= w_in_illegal;
`ifdef IMM_DECODE_CTRL_SKID_EN
        end else if (w_load_main_skid) begin
            r_ins     <= r_skid_ins;
            r_pc      <= r_skid_pc;
            r_type    <= r_skid_type;
            r_illegal <= r_skid_illegal;
`endif
        end
    end

`ifdef IMM_DECODE_CTRL_SKID_EN
    // Skid register: catches the beat accepted while the consumer stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_skid_ins     <= 32'd0;
            r_skid_pc      <= 64'd0;
            r_skid_type    <= TYPE_R;
            r_skid_illegal <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_ins     <= IN_INS;
            r_skid_pc      <= IN_PC;
            r_skid_type    <= w_in_type;
            r_skid_illegal <= w_in_illegal;
        end
    end

    // Registered ready: open unless the block will be full next cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end
`endif

endmodule
